// File: rtl/capture_sequencer.sv
// capture_sequencer: run-control FSM that walks the sample packet generator
// through one capture (idle -> pre-trigger fill -> post-trigger -> done),
// qualifies the external trigger against the pre-trigger depth and reports
// status plus trigger latency to the host.
module capture_sequencer #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort_req,
  input  logic                   force_trigger,
  input  logic                   trigger_in,
  input  logic                   write_enable,
  input  logic                   complete,
  input  logic [COUNT_WIDTH-1:0] preTriggerSampleCountMax,
  output logic                   idle,
  output logic                   preTrigger,
  output logic                   postTrigger,
  output logic                   triggered,
  output logic                   abort,
  output logic                   done,
  output logic                   aborted,
  output logic                   trig_armed,
  output logic [COUNT_WIDTH-1:0] trigger_latency,
  output logic [1:0]             state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_POST = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
  logic [COUNT_WIDTH-1:0] latency_q, latency_d;
  logic                   aborted_q, aborted_d;
  logic                   armed;

  // Arming is only meaningful while filling; outside PRE it reads as 0.
  assign armed = (state_q == S_PRE) && (pre_cnt_q >= preTriggerSampleCountMax);

  assign idle            = (state_q == S_IDLE);
  assign preTrigger      = (state_q == S_PRE);
  assign postTrigger     = (state_q == S_POST);
  assign done            = (state_q == S_DONE);
  assign aborted         = aborted_q;
  assign trig_armed      = armed;
  assign trigger_latency = latency_q;
  assign state           = state_q;

  // Next-state, counter updates and the zero-latency trigger/abort pulses.
  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    latency_d = latency_q;
    aborted_d = aborted_q;
    triggered = 1'b0;
    abort     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_PRE;
          pre_cnt_d = '0;
          latency_d = '0;
          aborted_d = 1'b0;
        end
      end
      S_PRE: begin
        if (abort_req) begin
          abort     = 1'b1;
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else begin
          if (write_enable && (pre_cnt_q < preTriggerSampleCountMax)) begin
            pre_cnt_d = pre_cnt_q + CNT_ONE;
          end
          if ((trigger_in && armed) || force_trigger) begin
            triggered = 1'b1;
            state_d   = S_POST;
          end else if (latency_q != CNT_MAX) begin
            latency_d = latency_q + CNT_ONE;
          end
        end
      end
      S_POST: begin
        if (abort_req) begin
          abort     = 1'b1;
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (complete) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          state_d   = S_PRE;
          pre_cnt_d = '0;
          latency_d = '0;
          aborted_d = 1'b0;
        end else if (abort_req) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pre_cnt_q <= '0;
      latency_q <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      latency_q <= latency_d;
      aborted_q <= aborted_d;
    end
  end

endmodule
